// File: rtl/intf_view_rr_collector.sv
// Round-robin collector: NCH view-adjusted channels into one registered valid/ready stream.
// Each lane applies its view offset independently; the top arbitrates and registers one word.

module intf_view_rr_lane #(
  parameter int W     = 32,
  parameter int OFS_A = 1,
  parameter int OFS_B = 2
) (
  input  logic [W-1:0] data,
  input  logic [1:0]   view,
  output logic [W-1:0] adj
);
  // Code 11 is treated as plain; sums wrap at W bits.
  always_comb begin
    case (view)
      2'b01:   adj = data + W'(OFS_A);
      2'b10:   adj = data + W'(OFS_B);
      default: adj = data;
    endcase
  end
endmodule

module intf_view_rr_collector #(
  parameter int NCH   = 5,
  parameter int W     = 32,
  parameter int BASE  = 4,
  parameter int OFS_A = 1,
  parameter int OFS_B = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   in_valid,
  input  logic [NCH*W-1:0] in_data,
  input  logic [2*NCH-1:0] in_view,
  output logic [NCH-1:0]   in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [7:0]       out_chan,
  output logic [15:0]      xfer_count
);
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef struct packed {
    logic [W-1:0] data;
    logic [7:0]   chan;
  } out_word_t;

  logic [NCH-1:0][W-1:0] adj;
  logic [PW-1:0]         ptr, sel;
  logic                  found, can_load, grant, drain;
  out_word_t             out_q;

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    intf_view_rr_lane #(.W(W), .OFS_A(OFS_A), .OFS_B(OFS_B)) u_lane (
      .data (in_data[i*W +: W]),
      .view (in_view[2*i +: 2]),
      .adj  (adj[i])
    );
  end

  assign drain    = out_valid && out_ready;
  assign can_load = !out_valid || out_ready;

  // Search from ptr upward with wrap; the first valid channel wins.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      int            j;
      logic [PW-1:0] jj;
      j = int'(ptr) + k;
      if (j >= NCH) j = j - NCH;
      jj = PW'(j);
      if (!found && in_valid[jj]) begin
        found = 1'b1;
        sel   = jj;
      end
    end
  end

  assign grant    = can_load && found && !rst;
  assign in_ready = grant ? (NCH'(1) << sel) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_q      <= '0;
      xfer_count <= '0;
      ptr        <= '0;
    end else begin
      if (drain) xfer_count <= xfer_count + 16'd1;
      if (grant) begin
        out_q.data <= adj[sel];
        out_q.chan <= 8'(BASE + int'(sel));
        out_valid  <= 1'b1;
        ptr        <= (sel == PW'(NCH-1)) ? '0 : sel + PW'(1);
      end else if (drain) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign out_data = out_q.data;
  assign out_chan = out_q.chan;
endmodule
